// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder block: FSM state encoding and
// the select-width to output-width mapping.
package scan_decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic int unsigned out_width(input int unsigned n_sel);
        return 32'd1 << n_sel;
    endfunction

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational N-to-2^N one-hot decoder; one output bit per select value.
module onehot_dec
    import scan_decoder_pkg::*;
#(
    parameter int N_SEL  = 3,
    localparam int OUT_W = out_width(N_SEL)
) (
    input  logic [N_SEL-1:0] sel_i,
    output logic [OUT_W-1:0] y_o
);

    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_line
        localparam logic [N_SEL-1:0] LINE_IDX = gi;
        assign y_o[gi] = (sel_i == LINE_IDX);
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot line decoder with direct mode and an auto-scan mode that
// walks the active line through every output with a programmable dwell.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int N_SEL   = 3,
    parameter int DWELL_W = 8,
    localparam int OUT_W  = out_width(N_SEL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               mode_i,
    input  logic [N_SEL-1:0]   sel_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               start_i,
    output logic [OUT_W-1:0]   y_o,
    output logic [N_SEL-1:0]   idx_o,
    output logic               busy_o,
    output logic               wrap_o
);

    state_t               state_q, state_d;
    logic [N_SEL-1:0]     idx_q, idx_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]     y_q, y_d;
    logic                 wrap_q, wrap_d;

    logic [N_SEL-1:0]     dec_sel;
    logic [OUT_W-1:0]     dec_y;
    logic [N_SEL-1:0]     idx_inc;
    logic                 load_y;

    onehot_dec #(
        .N_SEL (N_SEL)
    ) u_dec (
        .sel_i (dec_sel),
        .y_o   (dec_y)
    );

    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        dec_sel = sel_i;
        load_y  = 1'b0;

        if (!en_i) begin
            load_y = 1'b0;
        end else if (!mode_i) begin
            state_d = IDLE;
            idx_d   = sel_i;
            load_y  = 1'b1;
        end else if (state_q == IDLE) begin
            if (start_i) begin
                state_d = SCAN;
                idx_d   = sel_i;
                cnt_d   = dwell_i;
                load_y  = 1'b1;
            end
        end else if (y_q == '0) begin
            // In SCAN an all-zero y only follows a pause: re-show the held
            // line with a fresh dwell rather than stepping.
            dec_sel = idx_q;
            cnt_d   = dwell_i;
            load_y  = 1'b1;
        end else if (cnt_q == '0) begin
            dec_sel = idx_inc;
            idx_d   = idx_inc;
            cnt_d   = dwell_i;
            wrap_d  = (idx_q == '1);
            load_y  = 1'b1;
        end else begin
            dec_sel = idx_q;
            cnt_d   = cnt_q - 1'b1;
            load_y  = 1'b1;
        end

        y_d = load_y ? dec_y : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y_o    = y_q;
    assign idx_o  = idx_q;
    assign busy_o = (state_q == SCAN);
    assign wrap_o = wrap_q;

endmodule
